// File: rtl/dest_scoreboard_if.sv
// Issue/retire signal bundle between the issue stage and the destination scoreboard.
interface dest_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_BITS = 5
);
    logic                flush;
    logic                hold;
    logic                issue_valid;
    logic                issue_has_dest;
    logic [REG_BITS-1:0] issue_rd;
    logic                issue_rs_used;
    logic [REG_BITS-1:0] issue_rs;
    logic                issue_rt_used;
    logic [REG_BITS-1:0] issue_rt;
    logic                hazard;
    logic                issue_accept;
    logic [NUM_REGS-1:0] busy_vec;
    logic                retire_valid;
    logic [REG_BITS-1:0] retire_rd;

    modport master (
        output flush, hold, issue_valid, issue_has_dest, issue_rd,
               issue_rs_used, issue_rs, issue_rt_used, issue_rt,
        input  hazard, issue_accept, busy_vec, retire_valid, retire_rd
    );

    modport slave (
        input  flush, hold, issue_valid, issue_has_dest, issue_rd,
               issue_rs_used, issue_rs, issue_rt_used, issue_rt,
        output hazard, issue_accept, busy_vec, retire_valid, retire_rd
    );
endinterface

// File: rtl/dest_scoreboard.sv
// Register-destination scoreboard: tracks in-flight writers between issue and
// writeback, stalls issue on RAW hazards, retires entries at the last slot.
module dest_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_BITS  = 5,
    parameter int DEPTH     = 3,
    parameter int CNT_BITS  = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic             clock,
    input  logic             reset,
    dest_scoreboard_if.slave sb
);

    logic                slot_vld_q [DEPTH];
    logic                slot_vld_d [DEPTH];
    logic [REG_BITS-1:0] slot_rd_q  [DEPTH];
    logic [REG_BITS-1:0] slot_rd_d  [DEPTH];
    logic [CNT_BITS-1:0] pending_q  [NUM_REGS];
    logic [CNT_BITS-1:0] pending_d  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec_q;
    logic [NUM_REGS-1:0] busy_vec_d;

    logic                retire_valid;
    logic [REG_BITS-1:0] retire_rd;
    logic [CNT_BITS-1:0] rs_cnt;
    logic [CNT_BITS-1:0] rt_cnt;
    logic                rs_haz;
    logic                rt_haz;
    logic                hazard;
    logic                issue_accept;
    logic                tracked;

    // A register is pending unless its only outstanding writer retires this
    // very cycle and the register file write lands before the read.
    function automatic logic eff_pending(
        input logic [CNT_BITS-1:0] cnt,
        input logic [REG_BITS-1:0] r,
        input logic                rvld,
        input logic [REG_BITS-1:0] rrd,
        input logic                hold
    );
        logic busy;
        busy = (cnt != '0);
        if (WB_BYPASS != 0 && rvld && !hold && rrd == r && cnt == CNT_BITS'(1))
            busy = 1'b0;
        return busy;
    endfunction

    // Retire port, source lookups and the issue decision.
    always_comb begin
        retire_valid = slot_vld_q[DEPTH-1];
        retire_rd    = retire_valid ? slot_rd_q[DEPTH-1] : '0;
        rs_cnt       = '0;
        rt_cnt       = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sb.issue_rs == REG_BITS'(i)) rs_cnt = pending_q[i];
            if (sb.issue_rt == REG_BITS'(i)) rt_cnt = pending_q[i];
        end
        rs_haz = sb.issue_rs_used && (sb.issue_rs != '0) &&
                 eff_pending(rs_cnt, sb.issue_rs, retire_valid, retire_rd, sb.hold);
        rt_haz = sb.issue_rt_used && (sb.issue_rt != '0) &&
                 eff_pending(rt_cnt, sb.issue_rt, retire_valid, retire_rd, sb.hold);
        hazard       = sb.issue_valid && (rs_haz || rt_haz);
        issue_accept = sb.issue_valid && !hazard && !sb.hold && !sb.flush;
        tracked      = issue_accept && sb.issue_has_dest && (sb.issue_rd != '0);
    end

    // Next state: flush clears everything, hold freezes, otherwise shift and count.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_rd_d  = slot_rd_q;
        pending_d  = pending_q;
        if (sb.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_vld_d[i] = 1'b0;
                slot_rd_d[i]  = '0;
            end
            for (int i = 0; i < NUM_REGS; i++) pending_d[i] = '0;
        end else if (!sb.hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_vld_d[i] = slot_vld_q[i-1];
                slot_rd_d[i]  = slot_rd_q[i-1];
            end
            slot_vld_d[0] = tracked;
            slot_rd_d[0]  = tracked ? sb.issue_rd : '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                // Simultaneous issue and retire of the same register nets to zero.
                if (tracked && sb.issue_rd == REG_BITS'(i) &&
                    !(retire_valid && retire_rd == REG_BITS'(i)))
                    pending_d[i] = pending_q[i] + CNT_BITS'(1);
                else if (retire_valid && retire_rd == REG_BITS'(i) &&
                         !(tracked && sb.issue_rd == REG_BITS'(i)))
                    pending_d[i] = pending_q[i] - CNT_BITS'(1);
            end
        end
        for (int i = 0; i < NUM_REGS; i++) busy_vec_d[i] = (pending_d[i] != '0);
    end

    // Control state: slot valids, pending counters, busy vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)    slot_vld_q[i] <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) pending_q[i]  <= '0;
            busy_vec_q <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            pending_q  <= pending_d;
            busy_vec_q <= busy_vec_d;
        end
    end

    // Slot register indices; only meaningful alongside their valid bit.
    always_ff @(posedge clock) begin
        slot_rd_q <= slot_rd_d;
    end

    assign sb.hazard       = hazard;
    assign sb.issue_accept = issue_accept;
    assign sb.busy_vec     = busy_vec_q;
    assign sb.retire_valid = retire_valid;
    assign sb.retire_rd    = retire_rd;

endmodule

// File: doc/dest_scoreboard.md
Name: dest_scoreboard

Overview:
- Parametrised register-destination scoreboard for the pipelined CPU.
- Tracks in-flight instructions that will write a destination register, raises a RAW hazard stall for the issue stage, and retires entries at writeback.
- Consumes the per-instruction "has destination" and rd decode from the instruction parsers. Register 0 is never tracked.
- Generalises the single-instruction destination check to a multi-stage, multi-write tracker with flush, hold and writeback-bypass modes.

Parameters:
- NUM_REGS, 32: architectural register count.
- REG_BITS, 5: register index width; NUM_REGS must be <= 2^REG_BITS.
- DEPTH, 3: pipeline slots between issue and writeback retirement; must be >= 1.
- CNT_BITS, 2: per-register pending counter width; must satisfy 2^CNT_BITS > DEPTH.
- WB_BYPASS, 1: 1 = a register retiring this cycle is not treated as pending (register file writes early in the cycle); 0 = conservative.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  clears all in-flight entries, e.g. on a taken branch or jump.
- hold  in  1  whole pipeline frozen: no shift, issue or retire.
- issue_valid  in  1  instruction present at issue.
- issue_has_dest  in  1  instruction writes a register.
- issue_rd  in  REG_BITS  destination register.
- issue_rs_used  in  1  rs is read.
- issue_rs  in  REG_BITS  source register s.
- issue_rt_used  in  1  rt is read.
- issue_rt  in  REG_BITS  source register t.
- hazard  out  1  combinational; issue must stall.
- issue_accept  out  1  combinational; the issue is taken this cycle.
- busy_vec  out  NUM_REGS  registered; bit r = pending[r] != 0.
- retire_valid  out  1  combinational; slot DEPTH-1 holds a valid entry.
- retire_rd  out  REG_BITS  rd of slot DEPTH-1, or 0 when retire_valid is 0.

Behaviour:
- State:
  - Shift register of DEPTH slots, each {valid, rd}; slot 0 is the youngest.
  - pending[NUM_REGS] counters of CNT_BITS each.
- Reset, and flush at the same edge: all slots invalid, all counters 0, busy_vec 0. Outputs therefore settle to hazard=0, issue_accept=issue_valid & ~hold, retire_valid=0, retire_rd=0.
- Flush has priority over issue and retire at that edge. Flush while hold=1 still clears.
- Effective pending for a source register r:
  - pending[r] != 0;
  - when WB_BYPASS=1, minus the retiring entry: if retire_valid & ~hold & retire_rd==r and pending[r]==1, then r is not pending.
- Source hazard per operand: used & (src != 0) & effective pending(src).
- hazard = issue_valid & (rs hazard | rt hazard). It is computed even while hold=1.
- issue_accept = issue_valid & ~hazard & ~hold & ~flush.
- tracked = issue_accept & issue_has_dest & (issue_rd != 0).
- Each edge with hold=0 and flush=0:
  - slots shift: slot i+1 <= slot i;
  - slot 0 <= {tracked, tracked ? issue_rd : 0}, so a hazard inserts a bubble;
  - if retire_valid: pending[retire_rd] decrements;
  - if tracked: pending[issue_rd] increments;
  - if both target the same register, the net change is 0 (no glitch to 0 or overflow).
- hold=1, flush=0: all state unchanged.
- Invariant: pending[r] equals the number of valid slots with rd==r, which is at most DEPTH. Underflow or overflow is impossible; verification asserts it.
- busy_vec registers the post-update pending != 0, so it has 1-cycle latency after issue and retire.
- Retirement latency: a tracked issue at edge k reaches slot DEPTH-1 after DEPTH-1 further advancing edges and is decremented at the next advancing edge.

Test Plan:
- Reset, then issue rd=5 with no sources -> issue_accept=1; busy_vec[5]=1 next cycle; with DEPTH=3 and no hold, retire_valid=1, retire_rd=5 two cycles later; busy_vec[5]=0 after the following edge.
- Issue rd=5, then next cycle an instruction reading rs=5 -> hazard=1, issue_accept=0, slot 0 gets a bubble.
  - WB_BYPASS=1: hazard clears in the cycle retire_rd=5, i.e. 2 stall cycles.
  - WB_BYPASS=0: hazard clears one cycle later, i.e. 3 stall cycles.
- Two back-to-back writes to rd=7 -> pending[7]=2. First retire leaves busy_vec[7]=1; busy_vec[7]=0 only after the second retires. A third write to r7 issued in the same cycle as a retire keeps the count unchanged.
- Issue with rd=0, and reads of rs=0 / rt=0 -> never tracked, never hazard. rt_used=0 with rt matching a busy register -> no hazard.
- Fill the slots with rd=3,4,6, assert flush -> next cycle busy_vec=0, retire_valid=0, and a dependent read of r4 proceeds with hazard=0.
- Assert hold for 4 cycles mid-flight -> slots and busy_vec frozen, hazard still reflects pending state. Deassert -> retirement resumes exactly where it stopped. Assert reset mid-operation -> all cleared at the next edge.
